centroid_tracker: RTL and testbench
===================================

CENTROID_TRACKER -- requirements
Module: centroid_tracker

Interface
REQ-001 Parameter FRAME_W, default 640, meaning active columns; a column value >= FRAME_W marks an invalid sample.
REQ-002 Parameter FRAME_H, default 480, meaning active rows; a row value >= FRAME_H marks an invalid sample.
REQ-003 Parameter ALPHA_SHIFT, default 2, meaning EMA gain 1/2^ALPHA_SHIFT.
REQ-004 Parameters ACQ_FRAMES, default 3, and LOST_FRAMES, default 8, meaning frame counts for lock and loss.
REQ-005 Parameter JUMP_LIMIT, default 64, meaning maximum per-axis jump in pixels accepted while tracking.
REQ-006 Clock and reset are fixed: one clock, iVgaClk; reset is asynchronous, active-high, and named reset.
REQ-007 Ports SHALL be:
- iVgaClk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- iVgaVRequest  in  1  vertical active window
- iRedPixelHIndex  in  16  centroid row from the detector
- iRedPixelVIndex  in  16  centroid column from the detector
- iReady  in  1  consumer accepts the position
- oPosX  out  10  filtered column
- oPosY  out  9  filtered row
- oValid  out  1  new position available
- oState  out  2  tracker state
- oDropped  out  1  one-cycle pulse when an unaccepted position is overwritten

Function
REQ-008 Frame tick SHALL be the cycle after a registered falling edge of iVgaVRequest; both centroid inputs SHALL be latched on that cycle.
REQ-009 A sample SHALL be valid iff column < FRAME_W and row < FRAME_H.
REQ-010 States: SEARCH=0, ACQUIRE=1, TRACK=2, COAST=3; transitions occur only on frame ticks.
REQ-011 SEARCH transitions:
- valid sample -> ACQUIRE, with the position loaded directly from the sample and the hit counter set to 1.
- invalid sample -> stay in SEARCH.
REQ-012 ACQUIRE transitions:
- valid sample -> increment the hit counter and apply the EMA.
- hit counter reaches ACQ_FRAMES -> TRACK.
- invalid sample -> SEARCH.
REQ-013 TRACK transitions:
- valid sample with |dx| <= JUMP_LIMIT and |dy| <= JUMP_LIMIT -> apply the EMA.
- invalid sample or a larger jump -> COAST, with the miss counter set to 1 and the position held.
REQ-014 COAST transitions:
- sample accepted under the TRACK rule -> TRACK, with the miss counter cleared.
- otherwise -> increment the miss counter; at LOST_FRAMES go to SEARCH.
REQ-015 EMA per axis: pos <= pos + ((sample - pos) >>> ALPHA_SHIFT).
- Arithmetic: signed 12-bit difference, arithmetic shift, result saturated to [0, FRAME_W-1] or [0, FRAME_H-1].
REQ-016 oPosX and oPosY SHALL update 2 cycles after the frame tick; oValid SHALL rise on the same cycle, only in TRACK or COAST.
REQ-017 oValid SHALL stay high until a cycle with iReady=1; it clears on the following edge.
REQ-018 A new update arriving while oValid=1 and iReady=0 SHALL overwrite the position, keep oValid=1, and pulse oDropped.
- If iReady=1 on that same cycle, the update wins: oValid stays 1 and there is no oDropped pulse.
REQ-019 Hit and miss counters SHALL saturate and never wrap.

Reset
REQ-020 On reset:
- state = SEARCH, counters = 0, oValid = 0, oDropped = 0.
- oPosX = FRAME_W/2 and oPosY = FRAME_H/2.
- The edge-detect register is set to 0.
REQ-021 Reset asserted mid-frame SHALL discard the pending sample; the first tick after release requires a full falling edge of iVgaVRequest.

Configuration
REQ-022 With TRACKER_VELOCITY_EN defined, the block SHALL add signed 11-bit outputs oVelX and oVelY, equal to the change in filtered position between consecutive updates, zeroed on entering SEARCH.
REQ-023 Without TRACKER_VELOCITY_EN, the ports SHALL be absent and no velocity registers synthesized.

Structure
REQ-024 Package tracker_pkg SHALL hold the state encoding, default frame dimensions, and the coordinate width constants.
REQ-025 One sub-module, centroid_ema_axis (per-axis jump check, EMA, saturation), SHALL be instantiated twice.

Verification
REQ-026 Reset then 3 frames at (col 100, row 50) -> state goes 1 then 2; after frame 3 oValid=1 and oPosX=100, oPosY=50, 2 cycles after the tick.
REQ-027 In TRACK at (100,50), sample (140,50) with ALPHA_SHIFT=2 -> oPosX=110 with oPosY unchanged; sample (300,50) -> COAST, position held.
REQ-028 In TRACK, 8 frames with col=1023 -> COAST after frame 1, SEARCH after frame 8, oValid not reasserted.
REQ-029 Hold iReady=0 across 2 updates -> oDropped pulses once, oValid stays 1, oPosX shows the latest value; iReady=1 -> oValid=0 the next cycle.
REQ-030 Assert reset 10 cycles before a falling edge of iVgaVRequest -> no tick occurs and outputs are at reset values (320,240).
REQ-031 With TRACKER_VELOCITY_EN, updates 100 then 110 -> oVelX=+10; loss to SEARCH -> oVelX=0.

Source files
------------

// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - shared state encoding, frame defaults and coordinate widths
package tracker_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    COAST   = 2'd3
  } state_t;

  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 480;
  localparam int COORD_W     = 16;
  localparam int POS_X_W     = 10;
  localparam int POS_Y_W     = 9;
  localparam int DIFF_W      = 12;
  localparam int VEL_W       = 11;
  localparam int CNT_W       = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/centroid_ema_axis.sv
// rtl/centroid_ema_axis.sv - one axis: jump check, exponential smoothing step, clamp to frame
module centroid_ema_axis
  import tracker_pkg::*;
#(
  parameter int POS_W       = POS_X_W,
  parameter int LIMIT       = DEF_FRAME_W,
  parameter int ALPHA_SHIFT = 2,
  parameter int JUMP_LIMIT  = 64
) (
  input  logic [DIFF_W-1:0] sample,
  input  logic [POS_W-1:0]  pos,
  output logic [POS_W-1:0]  ema,
  output logic              near
);

  localparam logic signed [DIFF_W:0] MAX_S = (DIFF_W+1)'(LIMIT - 1);

  logic signed [DIFF_W-1:0] diff;
  logic signed [DIFF_W-1:0] step;
  logic signed [DIFF_W:0]   sum;
  logic        [DIFF_W-1:0] mag;

  assign diff = sample - {{(DIFF_W-POS_W){1'b0}}, pos};
  assign step = diff >>> ALPHA_SHIFT;
  assign sum  = {step[DIFF_W-1], step} + {{(DIFF_W+1-POS_W){1'b0}}, pos};

  // floor-rounded step keeps the result between pos and sample, the clamp is a safety net
  assign ema  = sum[DIFF_W]  ? '0 :
                (sum > MAX_S) ? POS_W'(LIMIT - 1) : sum[POS_W-1:0];

  assign mag  = diff[DIFF_W-1] ? -diff : diff;
  assign near = (mag <= DIFF_W'(JUMP_LIMIT));

endmodule

// File: rtl/centroid_tracker.sv
// rtl/centroid_tracker.sv - per-frame centroid lock/track/coast filter; TRACKER_VELOCITY_EN adds velocity outputs
module centroid_tracker
  import tracker_pkg::*;
#(
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int FRAME_H     = DEF_FRAME_H,
  parameter int ALPHA_SHIFT = 2,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int JUMP_LIMIT  = 64
) (
  input  logic               iVgaClk,
  input  logic               reset,
  input  logic               iVgaVRequest,
  input  logic [COORD_W-1:0] iRedPixelHIndex,
  input  logic [COORD_W-1:0] iRedPixelVIndex,
  input  logic               iReady,
  output logic [POS_X_W-1:0] oPosX,
  output logic [POS_Y_W-1:0] oPosY,
  output logic               oValid,
  output logic [1:0]         oState,
  output logic               oDropped
`ifdef TRACKER_VELOCITY_EN
  ,
  output logic signed [VEL_W-1:0] oVelX,
  output logic signed [VEL_W-1:0] oVelY
`endif
);

  logic               vreq_q, tick, proc;
  logic [COORD_W-1:0] samp_col, samp_row;
  state_t             state, state_nx;
  logic [CNT_W-1:0]   hit, hit_nx, miss, miss_nx;
  logic [POS_X_W-1:0] pos_x_nx, ema_x;
  logic [POS_Y_W-1:0] pos_y_nx, ema_y;
  logic               near_x, near_y, sample_ok, accept, update;

  // tick is one cycle after the registered falling edge; proc evaluates the latched sample
  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) begin
      vreq_q   <= 1'b0;
      tick     <= 1'b0;
      proc     <= 1'b0;
      samp_col <= '0;
      samp_row <= '0;
    end else begin
      vreq_q <= iVgaVRequest;
      tick   <= vreq_q & ~iVgaVRequest;
      proc   <= tick;
      if (tick) begin
        samp_col <= iRedPixelVIndex;
        samp_row <= iRedPixelHIndex;
      end
    end
  end

  assign sample_ok = (samp_col < COORD_W'(FRAME_W)) && (samp_row < COORD_W'(FRAME_H));
  assign accept    = sample_ok && near_x && near_y;

  centroid_ema_axis #(
    .POS_W(POS_X_W), .LIMIT(FRAME_W), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_LIMIT(JUMP_LIMIT)
  ) u_axis_x (
    .sample(samp_col[DIFF_W-1:0]), .pos(oPosX), .ema(ema_x), .near(near_x)
  );

  centroid_ema_axis #(
    .POS_W(POS_Y_W), .LIMIT(FRAME_H), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_LIMIT(JUMP_LIMIT)
  ) u_axis_y (
    .sample(samp_row[DIFF_W-1:0]), .pos(oPosY), .ema(ema_y), .near(near_y)
  );

  always_comb begin
    state_nx = state;
    hit_nx   = hit;
    miss_nx  = miss;
    pos_x_nx = oPosX;
    pos_y_nx = oPosY;
    if (proc) begin
      unique case (state)
        SEARCH: begin
          if (sample_ok) begin
            state_nx = ACQUIRE;
            hit_nx   = CNT_W'(1);
            miss_nx  = '0;
            pos_x_nx = samp_col[POS_X_W-1:0];
            pos_y_nx = samp_row[POS_Y_W-1:0];
          end
        end
        ACQUIRE: begin
          if (sample_ok) begin
            hit_nx   = sat_inc(hit);
            pos_x_nx = ema_x;
            pos_y_nx = ema_y;
            if (hit_nx >= CNT_W'(ACQ_FRAMES)) state_nx = TRACK;
          end else begin
            state_nx = SEARCH;
            hit_nx   = '0;
            miss_nx  = '0;
          end
        end
        TRACK: begin
          if (accept) begin
            pos_x_nx = ema_x;
            pos_y_nx = ema_y;
          end else begin
            state_nx = COAST;
            miss_nx  = CNT_W'(1);
          end
        end
        COAST: begin
          if (accept) begin
            state_nx = TRACK;
            miss_nx  = '0;
            pos_x_nx = ema_x;
            pos_y_nx = ema_y;
          end else begin
            miss_nx = sat_inc(miss);
            if (miss_nx >= CNT_W'(LOST_FRAMES)) begin
              state_nx = SEARCH;
              hit_nx   = '0;
              miss_nx  = '0;
            end
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  assign update = proc && ((state_nx == TRACK) || (state_nx == COAST));

  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      hit      <= '0;
      miss     <= '0;
      oPosX    <= POS_X_W'(FRAME_W / 2);
      oPosY    <= POS_Y_W'(FRAME_H / 2);
      oValid   <= 1'b0;
      oDropped <= 1'b0;
    end else begin
      state    <= state_nx;
      hit      <= hit_nx;
      miss     <= miss_nx;
      oPosX    <= pos_x_nx;
      oPosY    <= pos_y_nx;
      oDropped <= update & oValid & ~iReady;
      oValid   <= update | (oValid & ~iReady);
    end
  end

  assign oState = state;

`ifdef TRACKER_VELOCITY_EN
  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) begin
      oVelX <= '0;
      oVelY <= '0;
    end else if (proc) begin
      if (state_nx == SEARCH) begin
        oVelX <= '0;
        oVelY <= '0;
      end else if (update) begin
        oVelX <= $signed({1'b0, pos_x_nx}) - $signed({1'b0, oPosX});
        oVelY <= $signed({2'b0, pos_y_nx}) - $signed({2'b0, oPosY});
      end
    end
  end
`else
  // position-only build: no velocity state
`endif

endmodule

// File: tb/tb_centroid_tracker.sv
// tb/tb_centroid_tracker.sv - directed table plus randomized frames against a frame-level reference model
module tb_centroid_tracker;

  localparam int FW = 640;
  localparam int FH = 480;
  localparam int ASH = 2;
  localparam int ACQ = 3;
  localparam int LOST = 8;
  localparam int JLIM = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vreq = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] h_idx = '0;
  logic [15:0] v_idx = '0;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        valid;
  logic [1:0]  state;
  logic        dropped;
`ifdef TRACKER_VELOCITY_EN
  logic signed [10:0] vel_x, vel_y;
`endif

  always #5 clk = ~clk;

  centroid_tracker dut (
    .iVgaClk(clk),
    .reset(reset),
    .iVgaVRequest(vreq),
    .iRedPixelHIndex(h_idx),
    .iRedPixelVIndex(v_idx),
    .iReady(ready),
    .oPosX(pos_x),
    .oPosY(pos_y),
    .oValid(valid),
    .oState(state),
    .oDropped(dropped)
`ifdef TRACKER_VELOCITY_EN
    ,
    .oVelX(vel_x),
    .oVelY(vel_y)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference model: frame-level rules with plain integer arithmetic
  int m_st, m_hit, m_miss, m_x, m_y;
  bit m_v, m_d;
  int cap_st, cap_x, cap_y, cap_v, cap_d;

  function automatic int fdiv(input int d);
    int q;
    q = 1 << ASH;
    if (d >= 0) return d / q;
    return -((-d + q - 1) / q);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_hit = 0; m_miss = 0; m_x = FW / 2; m_y = FH / 2; m_v = 0; m_d = 0;
  endtask

  task automatic model_frame(input int col, input int row, input bit r);
    bit ok, near, old, upd;
    int nx, ny;
    ok   = (col < FW) && (row < FH);
    near = (iabs(col - m_x) <= JLIM) && (iabs(row - m_y) <= JLIM);
    nx   = clampi(m_x + fdiv(col - m_x), 0, FW - 1);
    ny   = clampi(m_y + fdiv(row - m_y), 0, FH - 1);
    old  = m_v & ~r;
    case (m_st)
      0: if (ok) begin m_st = 1; m_hit = 1; m_miss = 0; m_x = col; m_y = row; end
      1: if (ok) begin
           m_hit = (m_hit < 255) ? m_hit + 1 : 255;
           m_x = nx; m_y = ny;
           if (m_hit >= ACQ) m_st = 2;
         end else begin m_st = 0; m_hit = 0; m_miss = 0; end
      2: if (ok && near) begin m_x = nx; m_y = ny; end
         else begin m_st = 3; m_miss = 1; end
      default: if (ok && near) begin m_st = 2; m_miss = 0; m_x = nx; m_y = ny; end
         else begin
           m_miss = (m_miss < 255) ? m_miss + 1 : 255;
           if (m_miss >= LOST) begin m_st = 0; m_hit = 0; m_miss = 0; end
         end
    endcase
    upd = (m_st == 2) || (m_st == 3);
    m_d = upd && old;
    m_v = upd ? 1'b1 : old;
  endtask

  task automatic apply_frame(input int col, input int row, input bit r);
    @(posedge clk); #1;
    v_idx = col[15:0];
    h_idx = row[15:0];
    ready = r;
    vreq  = 1'b1;
    repeat (2) @(posedge clk);
    #1 vreq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_state", state, m_st);
    check("pre_x", pos_x, m_x);
    check("pre_y", pos_y, m_y);
    model_frame(col, row, r);
    @(posedge clk); @(negedge clk);
    cap_st = state; cap_x = pos_x; cap_y = pos_y; cap_v = valid; cap_d = dropped;
    check("post_state", cap_st, m_st);
    check("post_x", cap_x, m_x);
    check("post_y", cap_y, m_y);
    check("post_valid", cap_v, m_v);
    check("post_drop", cap_d, m_d);
    @(posedge clk); @(negedge clk);
    m_v = m_v & ~r;
    check("drop_clear", dropped, 0);
    check("valid_next", valid, m_v);
  endtask

  typedef struct {
    int col; int row; int r;
    int st; int x; int y; int v; int d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int col, input int row, input int r, input int st,
                              input int x, input int y, input int v, input int d);
    vec_t t;
    t.col = col; t.row = row; t.r = r; t.st = st; t.x = x; t.y = y; t.v = v; t.d = d;
    return t;
  endfunction

  initial begin
    int col, row, sel;
    bit r;

    tbl.push_back(mk(100,  50, 1, 1, 100,  50, 0, 0));
    tbl.push_back(mk(100,  50, 1, 1, 100,  50, 0, 0));
    tbl.push_back(mk(100,  50, 1, 2, 100,  50, 1, 0));
    tbl.push_back(mk(140,  50, 1, 2, 110,  50, 1, 0));
    tbl.push_back(mk(300,  50, 1, 3, 110,  50, 1, 0));
    tbl.push_back(mk(112,  50, 1, 2, 110,  50, 1, 0));
    tbl.push_back(mk(130,  50, 0, 2, 115,  50, 1, 0));
    tbl.push_back(mk(135,  50, 0, 2, 120,  50, 1, 1));
    for (int k = 0; k < 7; k++) tbl.push_back(mk(1023, 50, 1, 3, 120, 50, 1, 0));
    tbl.push_back(mk(1023, 50, 1, 0, 120,  50, 0, 0));
    tbl.push_back(mk(200, 100, 1, 1, 200, 100, 0, 0));
    tbl.push_back(mk(190,  97, 1, 1, 197,  99, 0, 0));
    tbl.push_back(mk(190,  97, 1, 2, 195,  98, 1, 0));
    tbl.push_back(mk(195, 480, 1, 3, 195,  98, 1, 0));
    tbl.push_back(mk(639,  98, 1, 3, 195,  98, 1, 0));
    tbl.push_back(mk(259,  98, 1, 2, 211,  98, 1, 0));
    tbl.push_back(mk(276,  98, 1, 3, 211,  98, 1, 0));
    tbl.push_back(mk(640,  98, 1, 3, 211,  98, 1, 0));

    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_x", pos_x, 320);
    check("rst_y", pos_y, 240);
    check("rst_valid", valid, 0);
    check("rst_drop", dropped, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_frame(tbl[i].col, tbl[i].row, tbl[i].r[0]);
      check($sformatf("tbl%0d_state", i), cap_st, tbl[i].st);
      check($sformatf("tbl%0d_x", i), cap_x, tbl[i].x);
      check($sformatf("tbl%0d_y", i), cap_y, tbl[i].y);
      check($sformatf("tbl%0d_valid", i), cap_v, tbl[i].v);
      check($sformatf("tbl%0d_drop", i), cap_d, tbl[i].d);
`ifdef TRACKER_VELOCITY_EN
      if (i == 3) check("vel_x_step", vel_x, 10);
      if (i == 15) check("vel_x_lost", vel_x, 0);
`endif
    end

    // reset held across a falling edge of the vertical window: no tick may leak through
    @(posedge clk); #1;
    v_idx = 16'd100; h_idx = 16'd50; ready = 1'b1; vreq = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1 vreq = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rstmid_state", state, 0);
    check("rstmid_x", pos_x, 320);
    check("rstmid_y", pos_y, 240);
    check("rstmid_valid", valid, 0);
    check("rstmid_drop", dropped, 0);
    apply_frame(100, 50, 1);
    check("after_rst_acq", cap_st, 1);

    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(7));
      r   = 1'($urandom_range(1));
      if (sel == 0) begin
        col = FW + int'($urandom_range(65535 - FW));
        row = int'($urandom_range(FH - 1));
      end else if (sel == 1) begin
        col = int'($urandom_range(FW - 1));
        row = FH + int'($urandom_range(100));
      end else if (sel == 2) begin
        col = int'($urandom_range(FW - 1));
        row = int'($urandom_range(FH - 1));
      end else begin
        col = clampi(m_x + int'($urandom_range(160)) - 80, 0, FW - 1);
        row = clampi(m_y + int'($urandom_range(160)) - 80, 0, FH - 1);
      end
      apply_frame(col, row, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
